// File: rtl/beam_scan_pkg.sv
// Shared types and constants for the beam scan controller.
package beam_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DWELL,
    EVAL,
    COMMIT
  } state_t;

  localparam int unsigned DEF_NUM_STEERS     = 32;
  localparam int unsigned DEF_SEL_W          = 5;
  localparam int unsigned DEF_DATA_W         = 22;
  localparam int unsigned DEF_SETTLE_SAMPLES = 4;
  localparam int unsigned DEF_DWELL_SAMPLES  = 256;

  // Hold-off margin is held_energy/8 when hysteresis is built in.
  localparam int unsigned HYST_SHIFT = 3;

  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned dwell);
    return data_w + $clog2(dwell);
  endfunction

endpackage

// File: rtl/beam_abs_acc.sv
// Magnitude of the scan-path sum accumulated over one dwell; clr dominates en.
module beam_abs_acc #(
  parameter int unsigned DATA_W = 22,
  parameter int unsigned ACC_W  = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] din,
  output logic        [ACC_W-1:0]  acc
);

  logic [DATA_W-1:0] w_mag;
  logic [ACC_W-1:0]  r_acc;

  // Most negative input wraps to 2^(DATA_W-1), which is correct as unsigned.
  assign w_mag = din[DATA_W-1] ? DATA_W'($unsigned(-din)) : DATA_W'($unsigned(din));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + ACC_W'(w_mag);
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/beam_scan_controller.sv
// Sweeps all steering directions, measures energy per direction and commits the loudest.
// Optional commit hysteresis is built in when BEAM_SCAN_HYST_EN is defined.
module beam_scan_controller
  import beam_scan_pkg::*;
#(
  parameter int unsigned NUM_STEERS     = DEF_NUM_STEERS,
  parameter int unsigned SEL_W          = DEF_SEL_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
  parameter int unsigned DWELL_SAMPLES  = DEF_DWELL_SAMPLES,
  parameter int unsigned ACC_W          = acc_width(DATA_W, DWELL_SAMPLES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     lr_clk,
  input  logic signed [DATA_W-1:0] scan_sum,
  output logic        [SEL_W-1:0]  scan_sel,
  output logic        [SEL_W-1:0]  steer_sel,
  output logic                     steer_valid,
  output logic                     sweep_done,
  output logic        [ACC_W-1:0]  best_energy
);

  localparam int unsigned MAX_CNT = (DWELL_SAMPLES > SETTLE_SAMPLES) ? DWELL_SAMPLES : SETTLE_SAMPLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  state_t           r_state;
  logic             r_lr_q;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_scan_sel;
  logic [SEL_W-1:0] r_steer_sel;
  logic [SEL_W-1:0] r_best_idx;
  logic [ACC_W-1:0] r_sweep_best;
  logic [ACC_W-1:0] r_best_energy;
  logic             r_steer_valid;
  logic             r_sweep_done;

  logic             w_strobe;
  logic             w_acc_clr;
  logic             w_acc_en;
  logic [ACC_W-1:0] w_acc;

  assign w_strobe  = lr_clk & ~r_lr_q;
  assign w_acc_clr = (r_state != DWELL);
  assign w_acc_en  = w_strobe && (r_state == DWELL);

  beam_abs_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_abs_acc (
    .clk (clk),
    .rst (rst),
    .clr (w_acc_clr),
    .en  (w_acc_en),
    .din (scan_sum),
    .acc (w_acc)
  );

`ifdef BEAM_SCAN_HYST_EN
  logic [ACC_W-1:0] r_held;
  logic [ACC_W:0]   w_thresh;
  logic             w_switch;

  // Switch only when the new winner beats the current direction by more than 1/8.
  assign w_thresh = {1'b0, r_held} + (ACC_W+1)'(r_held >> HYST_SHIFT);
  assign w_switch = !r_steer_valid || ({1'b0, r_sweep_best} > w_thresh);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_lr_q        <= 1'b0;
      r_cnt         <= '0;
      r_scan_sel    <= '0;
      r_steer_sel   <= '0;
      r_best_idx    <= '0;
      r_sweep_best  <= '0;
      r_best_energy <= '0;
      r_steer_valid <= 1'b0;
      r_sweep_done  <= 1'b0;
`ifdef BEAM_SCAN_HYST_EN
      r_held        <= '0;
`endif
    end else begin
      r_lr_q       <= lr_clk;
      r_sweep_done <= 1'b0;
      // Dropping enable abandons the partial sweep but keeps the committed result.
      if (!enable) begin
        r_state      <= IDLE;
        r_cnt        <= '0;
        r_scan_sel   <= '0;
        r_best_idx   <= '0;
        r_sweep_best <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt        <= '0;
            r_scan_sel   <= '0;
            r_best_idx   <= '0;
            r_sweep_best <= '0;
            r_state      <= SETTLE;
          end
          SETTLE: begin
            if (w_strobe) begin
              if (r_cnt == CNT_W'(SETTLE_SAMPLES - 1)) begin
                r_cnt   <= '0;
                r_state <= DWELL;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          DWELL: begin
            if (w_strobe) begin
              if (r_cnt == CNT_W'(DWELL_SAMPLES - 1)) begin
                r_cnt   <= '0;
                r_state <= EVAL;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          EVAL: begin
            // Strict greater-than keeps the lower index on ties.
            if ((w_acc > r_sweep_best) || (r_scan_sel == '0)) begin
              r_sweep_best <= w_acc;
              r_best_idx   <= r_scan_sel;
            end
`ifdef BEAM_SCAN_HYST_EN
            if (r_scan_sel == r_steer_sel) begin
              r_held <= w_acc;
            end
`endif
            if (r_scan_sel == SEL_W'(NUM_STEERS - 1)) begin
              r_state <= COMMIT;
            end else begin
              r_scan_sel <= r_scan_sel + SEL_W'(1);
              r_state    <= SETTLE;
            end
          end
          COMMIT: begin
`ifdef BEAM_SCAN_HYST_EN
            if (w_switch) begin
              r_steer_sel   <= r_best_idx;
              r_best_energy <= r_sweep_best;
            end else begin
              r_best_energy <= r_held;
            end
`else
            r_steer_sel   <= r_best_idx;
            r_best_energy <= r_sweep_best;
`endif
            r_steer_valid <= 1'b1;
            r_sweep_done  <= 1'b1;
            r_scan_sel    <= '0;
            r_state       <= SETTLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign scan_sel    = r_scan_sel;
  assign steer_sel   = r_steer_sel;
  assign steer_valid = r_steer_valid;
  assign sweep_done  = r_sweep_done;
  assign best_energy = r_best_energy;

endmodule

// File: tb/tb_beam_scan_controller.sv
// Scoreboard bench: each sweep pushes its expected commit, a monitor checks every sweep_done.
module tb_beam_scan_controller;

  localparam int unsigned NS     = 4;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned DATA_W = 22;
  localparam int unsigned SET_N  = 2;
  localparam int unsigned DW_N   = 8;
  localparam int unsigned ACC_W  = DATA_W + 3;

  typedef struct {
    int unsigned sel;
    longint      energy;
  } exp_t;

  logic                     clk;
  logic                     rst;
  logic                     enable;
  logic                     lr_clk;
  logic signed [DATA_W-1:0] scan_sum;
  logic        [SEL_W-1:0]  scan_sel;
  logic        [SEL_W-1:0]  steer_sel;
  logic                     steer_valid;
  logic                     sweep_done;
  logic        [ACC_W-1:0]  best_energy;

  exp_t exp_q[$];
  int   vals[NS];
  int   alt[NS];
  bit   tog;
  int   n_vec;
  int   n_err;
  int   done_cnt;

  beam_scan_controller #(
    .NUM_STEERS     (NS),
    .SEL_W          (SEL_W),
    .DATA_W         (DATA_W),
    .SETTLE_SAMPLES (SET_N),
    .DWELL_SAMPLES  (DW_N),
    .ACC_W          (ACC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .lr_clk      (lr_clk),
    .scan_sum    (scan_sum),
    .scan_sel    (scan_sel),
    .steer_sel   (steer_sel),
    .steer_valid (steer_valid),
    .sweep_done  (sweep_done),
    .best_energy (best_energy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame clock of 8 cycles; each new sample follows the direction under scan.
  initial begin
    lr_clk   = 1'b0;
    scan_sum = '0;
    tog      = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      lr_clk = ~lr_clk;
      if (lr_clk) begin
        tog      = ~tog;
        scan_sum = DATA_W'(vals[scan_sel[1:0]] + (tog ? alt[scan_sel[1:0]] : 0));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && sweep_done) begin
      exp_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sweep_done_unexpected: got steer_sel=%0d best_energy=%0d, want no pulse",
                 steer_sel, best_energy);
      end else begin
        e = exp_q.pop_front();
        if (int'(steer_sel) != e.sel || longint'(best_energy) != e.energy || steer_valid !== 1'b1) begin
          n_err++;
          $display("FAIL sweep_commit: got sel=%0d energy=%0d valid=%0b, want sel=%0d energy=%0d valid=1",
                   steer_sel, best_energy, steer_valid, e.sel, e.energy);
        end
      end
      done_cnt++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp_v);
    end
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
    if (done_cnt < target) begin
      n_vec++;
      n_err++;
      $display("FAIL sweep_timeout: got %0d commits want %0d", done_cnt, target);
    end
  endtask

  task automatic load(input int v0, input int v1, input int v2, input int v3, input int a3);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    alt[0]  = 0;  alt[1]  = 0;  alt[2]  = 0;  alt[3]  = a3;
  endtask

  task automatic run_sweep(input int v0, input int v1, input int v2, input int v3, input int a3,
                           input int unsigned e_sel, input longint e_energy);
    int target;
    load(v0, v1, v2, v3, a3);
    exp_q.push_back('{sel: e_sel, energy: e_energy});
    target = done_cnt + 1;
    enable = 1'b1;
    wait_done(target);
  endtask

  initial begin
    int saved;
    n_vec    = 0;
    n_err    = 0;
    done_cnt = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_scan_sel", longint'(scan_sel), 0);
    chk("rst_steer_sel", longint'(steer_sel), 0);
    chk("rst_steer_valid", longint'(steer_valid), 0);
    chk("rst_sweep_done", longint'(sweep_done), 0);
    chk("rst_best_energy", longint'(best_energy), 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_scan_sel", longint'(scan_sel), 0);
    end
    chk("idle_steer_valid", longint'(steer_valid), 0);
    chk("idle_best_energy", longint'(best_energy), 0);

    run_sweep(100, -300, 200, 50, 0, 1, 2400);
`ifdef BEAM_SCAN_HYST_EN
    run_sweep(500, 500, 500, 500, 0, 1, 4000);
`else
    run_sweep(500, 500, 500, 500, 0, 0, 4000);
`endif
    run_sweep(0, 0, -2097152, 0, 0, 2, 64'd16777216);

    // Abort during the dwell of index 2, then restart from index 0.
    load(0, 0, 0, 700, 0);
    saved  = done_cnt;
    enable = 1'b1;
    for (int i = 0; i < 2000 && scan_sel != SEL_W'(2); i++) @(negedge clk);
    chk("abort_reach_idx2", longint'(scan_sel), 2);
    repeat (30) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_scan_sel", longint'(scan_sel), 0);
    chk("abort_steer_sel", longint'(steer_sel), 2);
    chk("abort_best_energy", longint'(best_energy), 64'd16777216);
    chk("abort_steer_valid", longint'(steer_valid), 1);
    repeat (20) @(negedge clk);
    chk("abort_no_commit", longint'(done_cnt), longint'(saved));
    exp_q.push_back('{sel: 3, energy: 5600});
    enable = 1'b1;
    @(negedge clk);
    chk("restart_scan_sel", longint'(scan_sel), 0);
    wait_done(saved + 1);

    run_sweep(0, 125, 0, 0, 0, 1, 1000);
`ifdef BEAM_SCAN_HYST_EN
    run_sweep(0, 125, 0, 137, 1, 1, 1000);
`else
    run_sweep(0, 125, 0, 137, 1, 3, 1100);
`endif
    run_sweep(0, 125, 0, 150, 0, 3, 1200);

    enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
